adxl362_poller: RTL
===================

ADXL362_POLLER -- requirements
Module: adxl362_poller

Interface
REQ-001 Parameter CLK_FREQUENCY, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SAMPLE_HZ, default 100, accelerometer polling rate in Hz; sample period = CLK_FREQUENCY/SAMPLE_HZ cycles.
REQ-003 Parameter RESET_WAIT_CYCLES, default CLK_FREQUENCY/2000, post-soft-reset settle time.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  high permits periodic sampling after init.
REQ-007 host_req, host_write  input  1 each  host register-access request; write when host_write high.
REQ-008 host_addr, host_wdata  input  8 each  host register address and write data.
REQ-009 host_ack  output  1  one-cycle pulse when host transaction completes; host_rdata  output  8  read result.
REQ-010 spi_start, spi_write  output  1 each  command to adxl362_controller.
REQ-011 spi_addr, spi_wdata  output  8 each  register address and write data to adxl362_controller.
REQ-012 spi_busy, spi_done  input  1 each; spi_rdata  input  8  controller status and read data.
REQ-013 x_data, y_data, z_data, status  output  8 each  latest sample set; sample_valid  output  1  one-cycle pulse on update.
REQ-014 init_done, error, sample_overrun  output  1 each  status flags.

Function
REQ-015 Each SPI transaction: spi_start high exactly one cycle with address/write/data stable, then held stable until spi_done; next spi_start no earlier than the cycle after spi_done.
REQ-016 spi_start is issued only when spi_busy is low.
REQ-017 States: SRST_WR, SRST_WAIT, ID_RD, PWR_WR, IDLE, SAMPLE, HOST, ERROR.
REQ-018 SRST_WR: write 0x1F <- 0x52; SRST_WAIT: count RESET_WAIT_CYCLES after spi_done.
REQ-019 ID_RD: read 0x00; 0xAD -> PWR_WR, any other value -> ERROR.
REQ-020 PWR_WR: write 0x2D <- 0x02; on spi_done set init_done=1 and enter IDLE.
REQ-021 ERROR is terminal until reset: error=1, no spi_start, host_req ignored, no host_ack.
REQ-022 Sample timer runs only when init_done and enable are high, producing a one-cycle tick every sample period; a tick sets a pending flag.
REQ-023 IDLE: pending flag -> SAMPLE (clears flag); else host_req -> HOST; same-cycle pending and host_req -> SAMPLE first.
REQ-024 SAMPLE: reads 0x08, 0x09, 0x0A, 0x0B in order into shadow registers; x/y/z/status outputs update together, with sample_valid pulse, the cycle after the final spi_done.
REQ-025 Tick arriving while pending already set: sample_overrun pulses one cycle, pending stays set (no queueing beyond one).
REQ-026 HOST: one transaction from host_addr/host_wdata/host_write captured on entry; host_ack pulses one cycle after spi_done; host_rdata updates on reads only.
REQ-027 host_req held by host until host_ack; host_req before init_done waits.
REQ-028 enable deassertion mid-SAMPLE completes the current 4-read set; timer resets to zero and pending clears.

Reset
REQ-029 rst high: state SRST_WR, all outputs 0, timers, pending and shadow registers 0.
REQ-030 rst mid-transaction abandons it; after release the full init sequence restarts.

Structure
REQ-031 adxl362_pkg holds register addresses (0x00, 0x08-0x0B, 0x1F, 0x2D), constants 0xAD, 0x52, 0x02, and the state enum.
REQ-032 Sub-module adxl362_tick_gen: parameterised period counter with enable, output tick.

Verification
REQ-033 Release reset, controller stub (done 20 cycles after start, ID returns 0xAD) -> transactions W1F/52, wait, R00, W2D/02; init_done=1.
REQ-034 Stub returns ID 0x00 -> error=1, no further spi_start for 10 sample periods.
REQ-035 enable=1, stub returns 0x12/0x34/0x56/0x41 -> reads 08,09,0A,0B; x=0x12 y=0x34 z=0x56 status=0x41, one sample_valid pulse per period.
REQ-036 Idle host write 0x20<-0x55, then host read 0x00 -> one transaction each, host_ack pulses, host_rdata=0xAD.
REQ-037 host_req same cycle as tick -> SAMPLE reads complete first, then host transaction; sample_overrun stays 0.
REQ-038 rst asserted during second SAMPLE read -> outputs 0 next cycle; after release, sequence restarts at W1F/52.

Source files
------------

// File: rtl/adxl362_pkg.sv
// Shared register map, command constants, FSM states and SPI command payload
// used by the ADXL362 polling block.
package adxl362_pkg;

  localparam logic [7:0] REG_DEVID      = 8'h00;
  localparam logic [7:0] REG_XDATA      = 8'h08;
  localparam logic [7:0] REG_YDATA      = 8'h09;
  localparam logic [7:0] REG_ZDATA      = 8'h0A;
  localparam logic [7:0] REG_STATUS     = 8'h0B;
  localparam logic [7:0] REG_SOFT_RESET = 8'h1F;
  localparam logic [7:0] REG_POWER_CTL  = 8'h2D;

  localparam logic [7:0] DEVID_AD       = 8'hAD;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [7:0] POWER_MEASURE  = 8'h02;

  typedef enum logic [2:0] {
    ST_SRST_WR,
    ST_SRST_WAIT,
    ST_ID_RD,
    ST_PWR_WR,
    ST_IDLE,
    ST_SAMPLE,
    ST_HOST,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } spi_cmd_t;

  // Sample reads walk XDATA..STATUS, which are contiguous in the map.
  function automatic logic [7:0] sample_addr(input logic [1:0] idx);
    return REG_XDATA + 8'(idx);
  endfunction

endpackage

// File: rtl/adxl362_tick_gen.sv
// Free-running period counter: one-cycle tick every PERIOD enabled cycles,
// counter held at zero while disabled.
module adxl362_tick_gen #(
  parameter int unsigned PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/adxl362_poller.sv
// Brings up an ADXL362 through adxl362_controller, then polls XYZ/status at a
// fixed rate and arbitrates single host register accesses in between.
module adxl362_poller
  import adxl362_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY     = 100_000_000,
  parameter int unsigned SAMPLE_HZ         = 100,
  parameter int unsigned RESET_WAIT_CYCLES = CLK_FREQUENCY / 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       host_req,
  input  logic       host_write,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       spi_start,
  output logic       spi_write,
  output logic [7:0] spi_addr,
  output logic [7:0] spi_wdata,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_rdata,
  output logic [7:0] x_data,
  output logic [7:0] y_data,
  output logic [7:0] z_data,
  output logic [7:0] status,
  output logic       sample_valid,
  output logic       init_done,
  output logic       error,
  output logic       sample_overrun
);

  localparam int unsigned SAMPLE_PERIOD = CLK_FREQUENCY / SAMPLE_HZ;
  localparam int unsigned WAIT_W = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;

  state_t            state_q, state_d;
  logic              issued_q, issued_d;
  logic [1:0]        idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pending_q, pending_d;
  logic [7:0]        shx_q, shx_d, shy_q, shy_d, shz_q, shz_d;
  spi_cmd_t          hcmd_q, hcmd_d, cmd_q, cmd_d, req_cmd;
  logic              start_d, has_cmd, done_c, consume, tick;
  logic [7:0]        x_d, y_d, z_d, status_d, rdata_d;
  logic              valid_d, overrun_d, ack_d, init_d, error_d;
  logic              sample_run_c;

  assign sample_run_c = init_done && enable;
  assign spi_write    = cmd_q.write;
  assign spi_addr     = cmd_q.addr;
  assign spi_wdata    = cmd_q.wdata;

  adxl362_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (sample_run_c),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_SRST_WR;
      issued_q       <= 1'b0;
      idx_q          <= '0;
      wait_q         <= '0;
      pending_q      <= 1'b0;
      shx_q          <= '0;
      shy_q          <= '0;
      shz_q          <= '0;
      hcmd_q         <= '0;
      cmd_q          <= '0;
      spi_start      <= 1'b0;
      x_data         <= '0;
      y_data         <= '0;
      z_data         <= '0;
      status         <= '0;
      sample_valid   <= 1'b0;
      sample_overrun <= 1'b0;
      host_ack       <= 1'b0;
      host_rdata     <= '0;
      init_done      <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_q        <= state_d;
      issued_q       <= issued_d;
      idx_q          <= idx_d;
      wait_q         <= wait_d;
      pending_q      <= pending_d;
      shx_q          <= shx_d;
      shy_q          <= shy_d;
      shz_q          <= shz_d;
      hcmd_q         <= hcmd_d;
      cmd_q          <= cmd_d;
      spi_start      <= start_d;
      x_data         <= x_d;
      y_data         <= y_d;
      z_data         <= z_d;
      status         <= status_d;
      sample_valid   <= valid_d;
      sample_overrun <= overrun_d;
      host_ack       <= ack_d;
      host_rdata     <= rdata_d;
      init_done      <= init_d;
      error          <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    pending_d = pending_q;
    shx_d     = shx_q;
    shy_d     = shy_q;
    shz_d     = shz_q;
    hcmd_d    = hcmd_q;
    cmd_d     = cmd_q;
    start_d   = 1'b0;
    x_d       = x_data;
    y_d       = y_data;
    z_d       = z_data;
    status_d  = status;
    valid_d   = 1'b0;
    overrun_d = 1'b0;
    ack_d     = 1'b0;
    rdata_d   = host_rdata;
    init_d    = init_done;
    error_d   = error;
    req_cmd   = '0;
    has_cmd   = 1'b1;
    consume   = 1'b0;
    done_c    = issued_q && spi_done;

    // Command owned by each transaction state; captured into cmd_q on issue.
    case (state_q)
      ST_SRST_WR: req_cmd = '{write: 1'b1, addr: REG_SOFT_RESET, wdata: SOFT_RESET_KEY};
      ST_ID_RD:   req_cmd = '{write: 1'b0, addr: REG_DEVID,      wdata: 8'h00};
      ST_PWR_WR:  req_cmd = '{write: 1'b1, addr: REG_POWER_CTL,  wdata: POWER_MEASURE};
      ST_SAMPLE:  req_cmd = '{write: 1'b0, addr: sample_addr(idx_q), wdata: 8'h00};
      ST_HOST:    req_cmd = hcmd_q;
      default:    has_cmd = 1'b0;
    endcase

    if (has_cmd && !issued_q && !spi_busy) begin
      start_d  = 1'b1;
      cmd_d    = req_cmd;
      issued_d = 1'b1;
    end
    if (done_c) issued_d = 1'b0;

    case (state_q)
      ST_SRST_WR: if (done_c) begin
        state_d = ST_SRST_WAIT;
        wait_d  = '0;
      end
      ST_SRST_WAIT: begin
        if (32'(wait_q) + 32'd1 >= RESET_WAIT_CYCLES) state_d = ST_ID_RD;
        else wait_d = wait_q + 1'b1;
      end
      ST_ID_RD: if (done_c) begin
        if (spi_rdata == DEVID_AD) begin
          state_d = ST_PWR_WR;
        end else begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end
      end
      ST_PWR_WR: if (done_c) begin
        init_d  = 1'b1;
        state_d = ST_IDLE;
      end
      // Host is only accepted once its previous ack has been seen, so a still-high
      // host_req on the ack cycle is not taken as a new request.
      ST_IDLE: begin
        if (pending_q) begin
          consume = 1'b1;
          idx_d   = '0;
          state_d = ST_SAMPLE;
        end else if (host_req && !host_ack) begin
          hcmd_d  = '{write: host_write, addr: host_addr, wdata: host_wdata};
          state_d = ST_HOST;
        end
      end
      ST_SAMPLE: if (done_c) begin
        idx_d = idx_q + 1'b1;
        case (idx_q)
          2'd0: shx_d = spi_rdata;
          2'd1: shy_d = spi_rdata;
          2'd2: shz_d = spi_rdata;
          default: begin
            x_d      = shx_q;
            y_d      = shy_q;
            z_d      = shz_q;
            status_d = spi_rdata;
            valid_d  = 1'b1;
            state_d  = ST_IDLE;
          end
        endcase
      end
      ST_HOST: if (done_c) begin
        ack_d = 1'b1;
        if (!hcmd_q.write) rdata_d = spi_rdata;
        state_d = ST_IDLE;
      end
      default: error_d = 1'b1;
    endcase

    // One-deep sample request: a tick on top of an unconsumed one is flagged, not queued.
    if (!sample_run_c) begin
      pending_d = 1'b0;
    end else begin
      if (consume) pending_d = 1'b0;
      if (tick) begin
        if (pending_q && !consume) overrun_d = 1'b1;
        pending_d = 1'b1;
      end
    end
  end

endmodule
